fpu_arbiter: RTL
================

# fpu_arbiter

Round-robin arbiter and sequencer for the single shared `fpu_double` instance. It accepts operation requests (op, rounding mode, two 64-bit operands) from up to N_REQ requesters, such as the x/y/z derivative and update engines of the Lorenz datapath. It drives the FPU enable/reset handshake, waits for `ready`, and returns the result and exception flags to the granted requester. It also recovers from a hung FPU via a timeout.

## Interface
- N_REQ, 3, number of requesters (2..8)
- TIMEOUT, 255, max cycles waited for `fpu_ready` before abort (1..65535)
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- req  in  N_REQ  per-requester request level
- req_op  in  3*N_REQ  fpu_op per requester (0 add, 1 sub, 2 mul, 3 div), slice i = [3i+2:3i]
- req_rmode  in  2*N_REQ  rounding mode per requester
- req_opa, req_opb  in  64*N_REQ  operands per requester, slice i = [64i+63:64i]
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands of requester i captured
- done  out  N_REQ  one-hot, one-cycle pulse: result/flags valid for requester i
- result  out  64  FPU result, held until next `done`
- flags  out  5  {timeout, exception, inexact, underflow, overflow}, held with `result`
- busy  out  1  high from grant until return to IDLE
- fpu_rst, fpu_enable  out  1  to `fpu_double` rst/enable
- fpu_op  out  3; fpu_rmode  out  2; fpu_opa, fpu_opb  out  64  to `fpu_double`
- fpu_out  in  64; fpu_ready, fpu_overflow, fpu_underflow, fpu_inexact, fpu_exception  in  1  from `fpu_double`

## Operation
- States: IDLE, BUSY, RECOVER.
- IDLE: if any `req` bit is set, pick the first set bit at or after pointer `rr` (wrapping modulo N_REQ).
  - Latch that requester's op/rmode/opa/opb into the fpu_* outputs.
  - Pulse `gnt[i]`, set `fpu_enable`=1, clear the timeout counter, go to BUSY.
- BUSY: hold `fpu_enable`=1 and the operands stable. Count cycles.
  - On `fpu_ready`=1: `result`<=`fpu_out`; flags<={0, FPU flags}; pulse `done[i]`; `fpu_enable`<=0; `fpu_rst`<=1; go to RECOVER.
  - If the counter reaches TIMEOUT with no ready: `result`<=0; flags<=5'b10000; pulse `done[i]`; `fpu_enable`<=0; `fpu_rst`<=1; go to RECOVER.
- RECOVER: `fpu_rst`<=0; `rr`<=(i+1) mod N_REQ; go to IDLE.
- `req` is ignored outside IDLE. There is no queueing.
- A requester must hold `req` and its operands until `gnt`. It may withdraw `req` before `gnt` with no side effect.
- `req` still high in IDLE after `done` counts as a new request.
- `fpu_ready` arriving in the same cycle the counter hits TIMEOUT: ready wins and the timeout flag stays 0.
- Ready-with-exception is returned as a normal completion with the flag set. It is not retried.

## Timing
- Reset (`reset`=0 at a posedge) forces the following, from any state including mid-operation:
  - state=IDLE, `rr`=0, counter=0.
  - `gnt`=0, `done`=0, `result`=0, `flags`=0, `busy`=0.
  - `fpu_enable`=0, `fpu_rst`=1, fpu_op/rmode/opa/opb=0.
- The in-flight operation is discarded and no `done` is issued. `fpu_rst` drops to 0 on the first clock edge after reset is released.
- Grant: `req` seen at edge t gives `gnt`, `busy`, `fpu_enable` registered high after edge t.
- Completion: `fpu_ready` sampled at edge t gives `done`, `result`, `flags` valid after edge t, and `fpu_rst`=1 for exactly one cycle.
- Turnaround: earliest next `gnt` is two cycles after `done`.
- Overhead over raw FPU latency L: total occupancy = L + 3 cycles.
- Timeout: `done` with timeout flag is asserted exactly TIMEOUT+1 cycles after `gnt`.
- Outputs are all registered. There is no combinational path from `req` or `fpu_*` inputs to outputs.

## Test plan
- Single add: req[0], op=0, opa=0x3FF0000000000000, opb=0x4000000000000000 → gnt[0] one cycle; done[0] with result=0x4008000000000000, flags=0; fpu_rst pulses once.
- Contention: req=3'b111 held continuously → grant order 0,1,2,0,1,2; no requester is granted twice while another waits.
- Fairness after wrap: rr=2, req=3'b011 → gnt[0] first, then gnt[1].
- Timeout: FPU model never asserts ready, TIMEOUT=16 → done[i] 17 cycles after gnt, flags=5'b10000, result=0, next request serviced normally.
- Reset mid-BUSY: assert reset 3 cycles after gnt → no done; fpu_enable=0, fpu_rst=1 during reset; first request after release is granted to requester 0 when all requesters are active.
- Withdrawal and exception: req[1] pulsed for one cycle while BUSY → never granted. Then div 1.0/0.0 → done with exception flag as returned by the FPU.

Source files
------------

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter/sequencer sharing one fpu_double among N_REQ requesters,
// with enable/reset handshaking and a ready timeout to recover from a hung FPU.
module fpu_arbiter #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_op,
    input  logic [2*N_REQ-1:0]   req_rmode,
    input  logic [64*N_REQ-1:0]  req_opa,
    input  logic [64*N_REQ-1:0]  req_opb,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [63:0]          result,
    output logic [4:0]           flags,
    output logic                 busy,
    output logic                 fpu_rst,
    output logic                 fpu_enable,
    output logic [2:0]           fpu_op,
    output logic [1:0]           fpu_rmode,
    output logic [63:0]          fpu_opa,
    output logic [63:0]          fpu_opb,
    input  logic [63:0]          fpu_out,
    input  logic                 fpu_ready,
    input  logic                 fpu_overflow,
    input  logic                 fpu_underflow,
    input  logic                 fpu_inexact,
    input  logic                 fpu_exception
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0]      TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [N_REQ-1:0] ONE_HOT     = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, BUSY, RECOVER} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr;
    logic [IDX_W-1:0]   cur;
    logic [15:0]        count;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;

    // Scan requesters starting at the round-robin pointer, wrapping once.
    always_comb begin
        int idx;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!sel_valid && req[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rr         <= '0;
            cur        <= '0;
            count      <= '0;
            gnt        <= '0;
            done       <= '0;
            result     <= '0;
            flags      <= '0;
            busy       <= 1'b0;
            fpu_enable <= 1'b0;
            fpu_rst    <= 1'b1;
            fpu_op     <= '0;
            fpu_rmode  <= '0;
            fpu_opa    <= '0;
            fpu_opb    <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    fpu_rst <= 1'b0;
                    if (sel_valid) begin
                        cur        <= sel_idx;
                        gnt        <= ONE_HOT << sel_idx;
                        busy       <= 1'b1;
                        fpu_enable <= 1'b1;
                        count      <= '0;
                        fpu_op     <= req_op[3*sel_idx +: 3];
                        fpu_rmode  <= req_rmode[2*sel_idx +: 2];
                        fpu_opa    <= req_opa[64*sel_idx +: 64];
                        fpu_opb    <= req_opb[64*sel_idx +: 64];
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // Ready is checked first so it wins over a simultaneous timeout.
                    if (fpu_ready) begin
                        result     <= fpu_out;
                        flags      <= {1'b0, fpu_exception, fpu_inexact,
                                       fpu_underflow, fpu_overflow};
                        done       <= ONE_HOT << cur;
                        fpu_enable <= 1'b0;
                        fpu_rst    <= 1'b1;
                        state      <= RECOVER;
                    end else if (count == TIMEOUT_CNT) begin
                        result     <= '0;
                        flags      <= 5'b10000;
                        done       <= ONE_HOT << cur;
                        fpu_enable <= 1'b0;
                        fpu_rst    <= 1'b1;
                        state      <= RECOVER;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                RECOVER: begin
                    fpu_rst <= 1'b0;
                    busy    <= 1'b0;
                    rr      <= (cur == IDX_W'(N_REQ-1)) ? '0 : cur + 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
